// File: rtl/seq_serializer.sv
// Word FIFO feeding an MSB-first parallel-to-serial shifter with a downstream bit-consume enable.
// Back-to-back words stream without a ser_valid bubble when the FIFO has data at the last bit.
//
// state | meaning
// IDLE  | shifter empty, ser_valid=0, pops the FIFO head as soon as level>0
// SHIFT | shifter holds a word, ser_out = MSB of shift register, advances on ser_en
module seq_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     ser_en,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic push;
    logic pop;
    logic last_bit;
    logic fifo_empty;

    assign fifo_empty = (level == '0);
    assign in_ready   = (level != LVL_FULL);
    assign push       = in_valid && in_ready;
    assign last_bit   = (cnt == CNT_LAST);

    // Pop either to start from IDLE or to reload on the edge that consumes bit 0.
    assign pop = !fifo_empty &&
                 ((state == IDLE) || ((state == SHIFT) && ser_en && last_bit));

    assign ser_valid   = (state == SHIFT);
    assign ser_out     = ser_valid && shreg[WIDTH-1];
    assign frame_start = ser_valid && (cnt == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_en) begin
                        if (last_bit) begin
                            if (pop) begin
                                shreg <= mem[rd_ptr];
                                cnt   <= '0;
                            end else begin
                                shreg <= '0;
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    shreg <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: accepted words queue their expected bits, a negedge
// monitor pops and compares every consumed bit and checks occupancy against a word-level model.
module tb_seq_serializer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     nrst;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     in_ready;
    logic                     ser_en;
    logic                     ser_out;
    logic                     ser_valid;
    logic                     frame_start;
    logic [$clog2(DEPTH):0]   level;

    seq_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ser_en      (ser_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .level       (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Word-level reference: queued words, whether a word is in flight, bits of it consumed.
    int q_m[$];
    bit busy_m = 1'b0;
    int bits_done_m = 0;
    bit last_acc = 1'b0;
    // Expected bit stream: bit0 = ser_out, bit1 = frame_start.
    int exp_q[$];

    logic [3:0] hist = 4'b0;
    int det_hits = 0;
    int det_at = -1;
    int consumed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [WIDTH-1:0] d, input logic en);
        int had;
        int tmp;
        bit acc;
        had = q_m.size();
        acc = v && (had != DEPTH);
        if (busy_m) begin
            if (en) begin
                bits_done_m++;
                if (bits_done_m == WIDTH) begin
                    bits_done_m = 0;
                    if (had > 0) tmp = q_m.pop_front();
                    else busy_m = 1'b0;
                end
            end
        end else if (had > 0) begin
            tmp = q_m.pop_front();
            busy_m = 1'b1;
            bits_done_m = 0;
        end
        if (acc) begin
            q_m.push_back(int'(d));
            for (int i = WIDTH-1; i >= 0; i--)
                exp_q.push_back(((i == WIDTH-1) ? 2 : 0) + int'(d[i]));
        end
        last_acc = acc;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic en);
        in_valid = v;
        in_data  = d;
        ser_en   = en;
        @(posedge clk);
        model_edge(v, d, en);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_ser_valid", int'(ser_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_ser_out", int'(ser_out), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        q_m.delete();
        exp_q.delete();
        busy_m = 1'b0;
        bits_done_m = 0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || busy_m) && n < bound) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_timeout", int'(exp_q.size() != 0 || busy_m), 0);
    endtask

    always @(negedge clk) begin
        int e;
        chk("ser_valid", int'(ser_valid), int'(busy_m));
        chk("level", int'(level), q_m.size());
        chk("in_ready", int'(in_ready), int'(q_m.size() != DEPTH));
        if (!ser_valid) begin
            chk("idle_ser_out", int'(ser_out), 0);
            chk("idle_frame_start", int'(frame_start), 0);
        end else if (ser_en && nrst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ser_out", int'(ser_out), e % 2);
                chk("frame_start", int'(frame_start), e / 2);
            end
            hist = {hist[2:0], ser_out};
            if (hist == 4'b1011) begin
                det_hits++;
                det_at = consumed;
            end
            consumed++;
        end
    end

    initial begin
        int vcount;
        int ones;
        int sent;
        int cyc;
        logic [WIDTH-1:0] words [10];

        nrst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        ser_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_level", int'(level), 0);
        chk("init_in_ready", int'(in_ready), 1);
        nrst = 1'b1;

        // Single word 0xB0: latency, bit order, one detector hit on bit 4.
        hist = 4'b0; det_hits = 0; det_at = -1; consumed = 0;
        step(1'b1, 8'hB0, 1'b1);
        chk("accept_first_after_reset", int'(last_acc), 1);
        chk("latency_not_yet", int'(ser_valid), 0);
        step(1'b0, '0, 1'b1);
        chk("latency_first_bit_valid", int'(ser_valid), 1);
        chk("latency_first_frame", int'(frame_start), 1);
        drain(40);
        chk("detector_hits", det_hits, 1);
        chk("detector_position", det_at, 3);

        // Back-to-back words stream contiguously.
        step(1'b1, 8'hA5, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        drain(40);

        // Fill with ser_en low: 5 words held, 6th rejected.
        for (int i = 0; i < 6; i++) step(1'b1, WIDTH'(8'h10 + i), 1'b0);
        chk("full_last_rejected", int'(last_acc), 0);
        chk("full_level", int'(level), 4);
        chk("full_in_ready", int'(in_ready), 0);
        drain(80);

        // 0xFF with ser_en toggling: each bit held two cycles.
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, '0, 1'b0);
        vcount = int'(ser_valid);
        ones = int'(ser_valid && ser_out);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, logic'(i % 2));
            vcount += int'(ser_valid);
            ones += int'(ser_valid && ser_out);
        end
        chk("toggle_valid_cycles", vcount, 16);
        chk("toggle_ones", ones, 16);

        // Same-edge push and pop with level 2.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("pre_pushpop_level", int'(level), 2);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        chk("pushpop_accepted", int'(last_acc), 1);
        chk("pushpop_level", int'(level), 2);
        drain(80);

        // Ten distinct words through a wrapping FIFO.
        for (int i = 0; i < 10; i++) words[i] = WIDTH'(8'hC3 ^ (i * 8'h17));
        sent = 0;
        cyc = 0;
        while (sent < 10 && cyc < 300) begin
            step(1'b1, words[sent], 1'b1);
            if (last_acc) sent++;
            cyc++;
        end
        chk("wrap_all_sent", sent, 10);
        drain(120);

        // Reset mid-word discards everything.
        step(1'b1, 8'hB0, 1'b1);
        step(1'b1, 8'hB0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("pre_reset_busy", int'(ser_valid), 1);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        chk("post_reset_silent", int'(ser_valid), 0);
        step(1'b1, 8'h5A, 1'b1);
        chk("post_reset_accept", int'(last_acc), 1);
        drain(40);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 3) != 0), WIDTH'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 200; i++) begin
            step(logic'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 4) == 0));
        end
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bits per parallel word (minimum 2).
REQ-002 Parameter DEPTH, default 4, SHALL set the word FIFO depth (power of 2, minimum 2).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 nrst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that in_data holds a word to enqueue.
REQ-006 in_data  input  WIDTH  SHALL carry the parallel word; bit WIDTH-1 is transmitted first.
REQ-007 in_ready  output  1  SHALL indicate the FIFO can accept a word this cycle.
REQ-008 ser_en  input  1  SHALL be the downstream bit-consume enable; a bit advances only when it is high.
REQ-009 ser_out  output  1  SHALL carry the current serial bit, feeding the sequence detector's bit input.
REQ-010 ser_valid  output  1  SHALL be high while ser_out carries a valid bit.
REQ-011 frame_start  output  1  SHALL be high while ser_out carries bit WIDTH-1 of a word.
REQ-012 level  output  clog2(DEPTH)+1  SHALL report the current FIFO occupancy, 0..DEPTH.

Function
REQ-013 A push SHALL occur on a rising edge where in_valid and in_ready are both high; in_data is written at the tail.
REQ-014 in_ready SHALL equal (level != DEPTH) and SHALL NOT depend on a same-cycle pop; a full FIFO rejects pushes.
REQ-015 in_valid while in_ready is low SHALL be ignored with no state change.
REQ-016 The shifter SHALL have two states: IDLE (ser_valid=0) and SHIFT (ser_valid=1).
REQ-017 In IDLE with level>0, the next edge SHALL pop the head into the shift register, clear the bit counter, and enter SHIFT.
REQ-018 In SHIFT, ser_out SHALL equal shift-register bit WIDTH-1 combinationally, and frame_start SHALL equal (bit counter == 0).
REQ-019 In SHIFT with ser_en=1, the edge SHALL shift left by one, zero-filling, and increment the counter.
REQ-020 In SHIFT with ser_en=0, the shift register, counter and state SHALL hold.
REQ-021 On the edge consuming bit 0 (counter == WIDTH-1, ser_en=1): if level>0, the next word SHALL be popped and loaded that same edge, staying in SHIFT with no bubble; otherwise the block SHALL go to IDLE.
REQ-022 A push and a pop on the same edge SHALL leave level unchanged; head and tail pointers wrap modulo DEPTH.
REQ-023 Latency: a word pushed into an empty FIFO with the shifter in IDLE at edge N SHALL have its first bit on ser_out, with ser_valid=1, after edge N+1.
REQ-024 Total words held SHALL be at most DEPTH+1 (DEPTH in the FIFO plus one in the shifter).
REQ-025 In IDLE, ser_out SHALL be 0 and frame_start SHALL be 0.

Reset
REQ-026 While nrst=0, state SHALL be IDLE, the shift register, counter, pointers and level SHALL be 0, ser_valid=0, ser_out=0, frame_start=0, and in_ready=1.
REQ-027 Reset asserted mid-word SHALL immediately discard the partial word and all queued words; no bit SHALL be emitted after release until a new push.
REQ-028 The first push SHALL be accepted on the first rising edge after nrst deasserts.

Verification
REQ-029 WIDTH=8, ser_en=1: push 0xB0 -> ser_out 1,0,1,1,0,0,0,0 on 8 consecutive valid cycles; frame_start on the first only; the chained detector pulses once, on the 4th bit.
REQ-030 Push 0xA5 then 0x3C on consecutive edges, ser_en=1 -> 16 contiguous valid bits 10100101_00111100 with no ser_valid gap; frame_start pulses twice, 8 cycles apart.
REQ-031 ser_en=0, push continuously -> 5 words accepted (1 in shifter, 4 in FIFO), then level=4 and in_ready=0; a 6th in_valid is ignored.
REQ-032 Push 0xFF, toggle ser_en 1,0,1,0,... -> each bit holds 2 cycles; 16 cycles of ser_valid=1, all ser_out=1.
REQ-033 Push 0xB0 and 0xB0, assert nrst=0 after 3 bits -> ser_valid=0, level=0 and in_ready=1 immediately; after release, no further bits until a new push.
REQ-034 With level=2 and the shifter busy, push and pop on the same edge -> level stays 2; pointer wrap is checked by pushing 10 distinct words and comparing the serial output order.
